cache_2way_wb: RTL

Parametrised 2-way set-associative write-back cache with per-set LRU replacement and a request/ready handshake on both the CPU side and the memory side.
- Successor to the single-configuration L1 cache; the board top drives it from switches and shows status on LEDs/HEX.
- Sits between a requester (switch-driven FSM or CPU core) and a backing memory that acknowledges each access (on-chip RAM or a slower model).

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_way_store.sv | 80 ++++++++
 rtl/cache_2way_wb.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way write-back cache.
//   state_e  : controller states
//   clog2 / index_w / tag_w : address-split width derivation from SETS and ADDR_W
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_RESPOND
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) w = i + 1;
        end
        return w;
    endfunction

    function automatic int unsigned index_w(input int unsigned sets);
        return clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
        return addr_w - clog2(sets);
    endfunction

endpackage

// File: rtl/cache_way_store.sv
// One way of the cache: per-set tag, data, valid and dirty storage.
// Ports:
//   clk, rst_n            : clock, async active-low reset (clears valid/dirty only)
//   index, tag            : set being accessed and tag to compare against
//   hit                   : line at index is valid and its tag matches
//   line_valid/line_dirty : status bits of the line at index
//   line_tag, line_data   : stored tag/data of the line at index
//   fill_en, fill_data    : install a line (tag <= tag, valid=1, dirty=0)
//   store_en, store_data  : overwrite line data and mark dirty
module cache_way_store
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SETS   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [index_w(SETS)-1:0]           index,
    input  logic [tag_w(ADDR_W, SETS)-1:0]     tag,
    output logic                               hit,
    output logic                               line_valid,
    output logic                               line_dirty,
    output logic [tag_w(ADDR_W, SETS)-1:0]     line_tag,
    output logic [DATA_W-1:0]                  line_data,
    input  logic                               fill_en,
    input  logic [DATA_W-1:0]                  fill_data,
    input  logic                               store_en,
    input  logic [DATA_W-1:0]                  store_data
);

    localparam int unsigned TAG_W = tag_w(ADDR_W, SETS);

    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [DATA_W-1:0] data_q [SETS];
    logic [DATA_W-1:0] data_d [SETS];
    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];
    assign hit        = valid_q[index] && (tag_q[index] == tag);

    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            tag_d[index]   = tag;
            data_d[index]  = fill_data;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end
        if (store_en) begin
            data_d[index]  = store_data;
            dirty_d[index] = 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back, write-allocate cache with per-set LRU.
// Optional macro CACHE_STATS_EN adds 32-bit saturating hit_count/miss_count.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req, wren, address, data   : CPU request, accepted when req && ready
//   ready                      : high only in IDLE
//   done                       : one-cycle completion pulse
//   q, miss, valid, dirty, lru : result and line status of the completed access
//   mem_req, mem_wren, mem_address, mem_data : backing-memory request (held until mem_ack)
//   mem_q, mem_ack             : refill data and one-cycle completion from memory
module cache_2way_wb
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SETS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic              req,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] q,
    output logic              miss,
    output logic              valid,
    output logic              dirty,
    output logic              lru,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_ack
);

    localparam int unsigned INDEX_W = index_w(SETS);
    localparam int unsigned TAG_W   = tag_w(ADDR_W, SETS);

    state_e            state_q, state_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              way_q, way_d;
    logic [SETS-1:0]   lru_bits_q, lru_bits_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              miss_q, miss_d;
    logic              valid_q, valid_d;
    logic              dirty_q, dirty_d;
    logic              lru_out_q, lru_out_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         hit;
    logic [1:0]         line_valid;
    logic [1:0]         line_dirty;
    logic [TAG_W-1:0]   line_tag  [2];
    logic [DATA_W-1:0]  line_data [2];
    logic [1:0]         fill_en;
    logic [1:0]         store_en;
    logic               victim;
    logic               hit_way;

    assign idx = addr_q[INDEX_W-1:0];
    assign tag = addr_q[ADDR_W-1:INDEX_W];

    cache_way_store #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS)) u_way0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (idx),
        .tag        (tag),
        .hit        (hit[0]),
        .line_valid (line_valid[0]),
        .line_dirty (line_dirty[0]),
        .line_tag   (line_tag[0]),
        .line_data  (line_data[0]),
        .fill_en    (fill_en[0]),
        .fill_data  (mem_q),
        .store_en   (store_en[0]),
        .store_data (wdata_q)
    );

    cache_way_store #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS)) u_way1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (idx),
        .tag        (tag),
        .hit        (hit[1]),
        .line_valid (line_valid[1]),
        .line_dirty (line_dirty[1]),
        .line_tag   (line_tag[1]),
        .line_data  (line_data[1]),
        .fill_en    (fill_en[1]),
        .fill_data  (mem_q),
        .store_en   (store_en[1]),
        .store_data (wdata_q)
    );

    // Prefer an empty way (way 0 first), otherwise evict the LRU way.
    assign victim  = !line_valid[0] ? 1'b0 : (!line_valid[1] ? 1'b1 : lru_bits_q[idx]);
    // A double hit is impossible; way 0 wins defensively.
    assign hit_way = hit[0] ? 1'b0 : 1'b1;

    // Status outputs are registered on the edge entering RESPOND so that they
    // and done become visible together in the RESPOND cycle.
    always_comb begin
        state_d     = state_q;
        wren_d      = wren_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        way_d       = way_q;
        lru_bits_d  = lru_bits_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        miss_d      = miss_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        lru_out_d   = lru_out_q;
        fill_en     = '0;
        store_en    = '0;
        ready       = 1'b0;
        mem_req     = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;

        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    wren_d  = wren;
                    addr_d  = address;
                    wdata_d = data;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit != 2'b00) begin
                    way_d     = hit_way;
                    done_d    = 1'b1;
                    miss_d    = 1'b0;
                    valid_d   = 1'b1;
                    dirty_d   = wren_q | line_dirty[hit_way];
                    rdata_d   = wren_q ? wdata_q : line_data[hit_way];
                    lru_out_d = ~hit_way;
                    state_d   = S_RESPOND;
                end else begin
                    way_d   = victim;
                    state_d = (line_valid[victim] && line_dirty[victim]) ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_req     = 1'b1;
                mem_wren    = 1'b1;
                mem_address = {line_tag[way_q], idx};
                mem_data    = line_data[way_q];
                if (mem_ack) state_d = S_REFILL;
            end
            S_REFILL: begin
                mem_req     = 1'b1;
                mem_address = addr_q;
                if (mem_ack) begin
                    fill_en[way_q] = 1'b1;
                    done_d         = 1'b1;
                    miss_d         = 1'b1;
                    valid_d        = 1'b1;
                    dirty_d        = wren_q;
                    rdata_d        = wren_q ? wdata_q : mem_q;
                    lru_out_d      = ~way_q;
                    state_d        = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (wren_q) store_en[way_q] = 1'b1;
                lru_bits_d[idx] = ~way_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            way_q      <= 1'b0;
            lru_bits_q <= '0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            miss_q     <= 1'b0;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            lru_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            way_q      <= way_d;
            lru_bits_q <= lru_bits_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            miss_q     <= miss_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            lru_out_q  <= lru_out_d;
        end
    end

    assign done  = done_q;
    assign q     = rdata_q;
    assign miss  = miss_q;
    assign valid = valid_q;
    assign dirty = dirty_q;
    assign lru   = lru_out_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == S_RESPOND) begin
            if (miss_q) begin
                if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
            end else begin
                if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
